// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core controller and its interrupt context stack.
// Contents:
//   STATE_W  - width of the controller state encoding
//   state_e  - controller states (encoding 7 is unused and recovers to IDLE)
//   clog2    - ceiling log2 for deriving parameter widths
package core_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_HANDLER = 3'd3,
    ST_FLUSH   = 3'd4,
    ST_DONE    = 3'd5,
    ST_FAULT   = 3'd6
  } state_e;

  // Ceiling log2. Returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/irq_ctx_stack.sv
// LIFO of interrupt ids for nested handlers.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   push, pop      - push din / pop the top entry (never asserted together)
//   clear          - synchronous empty, takes precedence over push/pop
//   din            - id to push
//   top            - registered copy of the top entry, 0 when empty
//   level          - number of entries held
//   full, empty    - occupancy flags
module irq_ctx_stack
  import core_ctrl_pkg::*;
#(
  parameter int NEST_DEPTH = 2,
  parameter int ID_W       = 2,
  parameter int LVL_W      = clog2(NEST_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [ID_W-1:0]  din,
  output logic [ID_W-1:0]  top,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [ID_W-1:0]  mem_q [NEST_DEPTH];
  logic [LVL_W-1:0] level_q;
  logic [ID_W-1:0]  top_q;
  logic [ID_W-1:0]  below_top;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_q == LVL_W'(NEST_DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !clear && !full;
  assign do_pop  = pop && !clear && !push && !empty;

  // Entry that becomes the new top after a pop (slot level-2).
  always_comb begin
    below_top = '0;
    for (int i = 0; i < NEST_DEPTH; i++) begin
      if (int'(level_q) == i + 2) below_top = mem_q[i];
    end
  end

  for (genvar gi = 0; gi < NEST_DEPTH; gi++) begin : g_slot
    logic [ID_W-1:0] slot_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        slot_q <= '0;
      end else if (do_push && (int'(level_q) == gi)) begin
        slot_q <= din;
      end
    end
    assign mem_q[gi] = slot_q;
  end

  // The top is kept in its own register so irq_id is a clean flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      top_q   <= '0;
    end else if (clear) begin
      level_q <= '0;
      top_q   <= '0;
    end else if (do_push) begin
      level_q <= level_q + LVL_W'(1);
      top_q   <= din;
    end else if (do_pop) begin
      level_q <= level_q - LVL_W'(1);
      top_q   <= below_top;
    end
  end

  assign top   = top_q;
  assign level = level_q;

endmodule

// File: rtl/core_controller_irq_fsm.sv
// Core controller: sequences the pipeline through idle, run, interrupt
// drain/handler (with prioritised, maskable, nested interrupts), full flush,
// done and a watchdog fault state.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   master_reset                  - synchronous hard reset to IDLE
//   start_program, program_done   - boot / completion handshakes
//   reset_trigger                 - soft reset, forces a full flush
//   irq_req, irq_mask             - level requests, 1 = masked; index 0 wins
//   ret_from_irq                  - handler return pulse
//   fetch_ready, all_ready,
//   data_mem_reset_able           - drain / flush completion conditions
//   state_out                     - current state encoding
//   begin_execution ... fault_flag - registered control outputs
//   irq_ack, csr_swap_context     - one-cycle pulses on push/pop
//   irq_id, nest_level            - top-of-stack id and stack depth
module core_controller_irq_fsm
  import core_ctrl_pkg::*;
#(
  parameter int NUM_IRQ       = 4,
  parameter int NEST_DEPTH    = 2,
  parameter int TIMEOUT_W     = 8,
  parameter int FLUSH_TIMEOUT = 200,
  parameter int ID_W          = (clog2(NUM_IRQ) < 1) ? 1 : clog2(NUM_IRQ),
  parameter int LVL_W         = clog2(NEST_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               master_reset,
  input  logic               start_program,
  input  logic               program_done,
  input  logic               reset_trigger,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               ret_from_irq,
  input  logic               fetch_ready,
  input  logic               all_ready,
  input  logic               data_mem_reset_able,
  output logic [STATE_W-1:0] state_out,
  output logic               begin_execution,
  output logic               flush_partial,
  output logic               flush_full,
  output logic               global_reset,
  output logic               data_mem_stop_request_overide,
  output logic               csr_swap_context,
  output logic               run_irq_handler,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [ID_W-1:0]    irq_id,
  output logic [LVL_W-1:0]   nest_level,
  output logic               done_flag,
  output logic               fault_flag
);

  localparam logic [TIMEOUT_W-1:0] WD_LIMIT = TIMEOUT_W'(FLUSH_TIMEOUT);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      lat_id_q, lat_id_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d, wd_inc;
  logic [NUM_IRQ-1:0]   ack_q, ack_d;
  logic                 swap_q, swap_d;
  logic                 begin_exec_q, flush_partial_q, flush_full_q;
  logic                 global_reset_q, mem_stop_q, run_handler_q;
  logic                 done_q, fault_q;

  logic [NUM_IRQ-1:0]   eligible;
  logic                 any_elig;
  logic [ID_W-1:0]      winner;

  logic                 stk_push, stk_pop, stk_clear;
  logic [ID_W-1:0]      stk_top;
  logic [LVL_W-1:0]     stk_level;
  logic                 stk_full, stk_empty;

  assign eligible = irq_req & ~irq_mask;
  assign any_elig = |eligible;
  assign wd_inc   = wd_q + TIMEOUT_W'(1);

  // Priority encoder: scanning downward leaves the lowest set index.
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  irq_ctx_stack #(
    .NEST_DEPTH (NEST_DEPTH),
    .ID_W       (ID_W),
    .LVL_W      (LVL_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (stk_push),
    .pop   (stk_pop),
    .clear (stk_clear),
    .din   (lat_id_q),
    .top   (stk_top),
    .level (stk_level),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    state_d   = state_q;
    lat_id_d  = lat_id_q;
    wd_d      = wd_q;
    ack_d     = '0;
    swap_d    = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_program) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (reset_trigger) begin
          state_d   = ST_FLUSH;
          stk_clear = 1'b1;
          wd_d      = '0;
        end else if (any_elig) begin
          lat_id_d = winner;
          wd_d     = '0;
          state_d  = ST_DRAIN;
        end else if (program_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DRAIN: begin
        // Ready in the limit cycle still completes the drain.
        if (fetch_ready && data_mem_reset_able) begin
          stk_push = 1'b1;
          ack_d    = NUM_IRQ'(1) << lat_id_q;
          swap_d   = 1'b1;
          wd_d     = '0;
          state_d  = ST_HANDLER;
        end else if (wd_inc == WD_LIMIT) begin
          wd_d    = wd_inc;
          state_d = ST_FAULT;
        end else begin
          wd_d = wd_inc;
        end
      end
      ST_HANDLER: begin
        if (reset_trigger) begin
          state_d   = ST_FLUSH;
          stk_clear = 1'b1;
          wd_d      = '0;
        end else if (ret_from_irq && !stk_empty) begin
          // Return beats a simultaneous preempting request; the request is
          // seen again next cycle against the new top.
          stk_pop = 1'b1;
          swap_d  = 1'b1;
          if (stk_level == LVL_W'(1)) state_d = ST_RUN;
        end else if (any_elig && (winner < stk_top) && !stk_full) begin
          lat_id_d = winner;
          wd_d     = '0;
          state_d  = ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        if (all_ready && data_mem_reset_able) begin
          wd_d    = '0;
          state_d = ST_IDLE;
        end else if (wd_inc == WD_LIMIT) begin
          wd_d    = wd_inc;
          state_d = ST_FAULT;
        end else begin
          wd_d = wd_inc;
        end
      end
      ST_DONE:  state_d = ST_DONE;
      ST_FAULT: state_d = ST_FAULT;
      default: begin
        state_d   = ST_IDLE;
        stk_clear = 1'b1;
        wd_d      = '0;
      end
    endcase

    if (master_reset) begin
      state_d   = ST_IDLE;
      lat_id_d  = '0;
      wd_d      = '0;
      ack_d     = '0;
      swap_d    = 1'b0;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      stk_clear = 1'b1;
    end
  end

  // Level outputs are decoded from the next state and registered, so they
  // line up with state_q and carry no combinational path from the inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      lat_id_q        <= '0;
      wd_q            <= '0;
      ack_q           <= '0;
      swap_q          <= 1'b0;
      begin_exec_q    <= 1'b0;
      flush_partial_q <= 1'b0;
      flush_full_q    <= 1'b0;
      global_reset_q  <= 1'b0;
      mem_stop_q      <= 1'b0;
      run_handler_q   <= 1'b0;
      done_q          <= 1'b0;
      fault_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      lat_id_q        <= lat_id_d;
      wd_q            <= wd_d;
      ack_q           <= ack_d;
      swap_q          <= swap_d;
      begin_exec_q    <= (state_d == ST_RUN) || (state_d == ST_HANDLER);
      flush_partial_q <= (state_d == ST_DRAIN);
      flush_full_q    <= (state_d == ST_FLUSH);
      global_reset_q  <= (state_d == ST_FLUSH) || (state_d == ST_FAULT);
      mem_stop_q      <= (state_d == ST_DRAIN) || (state_d == ST_FLUSH);
      run_handler_q   <= (state_d == ST_HANDLER);
      done_q          <= (state_d == ST_DONE);
      fault_q         <= (state_d == ST_FAULT);
    end
  end

  assign state_out                     = state_q;
  assign begin_execution               = begin_exec_q;
  assign flush_partial                 = flush_partial_q;
  assign flush_full                    = flush_full_q;
  assign global_reset                  = global_reset_q;
  assign data_mem_stop_request_overide = mem_stop_q;
  assign csr_swap_context              = swap_q;
  assign run_irq_handler               = run_handler_q;
  assign irq_ack                       = ack_q;
  assign irq_id                        = stk_top;
  assign nest_level                    = stk_level;
  assign done_flag                     = done_q;
  assign fault_flag                    = fault_q;

endmodule

// File: tb/tb_core_controller_irq_fsm.sv
module tb_core_controller_irq_fsm;

  localparam int NUM_IRQ = 4;
  localparam int NEST_DEPTH = 2;
  localparam int TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       rst, master_reset, start_program, program_done, reset_trigger;
  logic [3:0] irq_req, irq_mask;
  logic       ret_from_irq, fetch_ready, all_ready, data_mem_reset_able;
  logic [2:0] state_out;
  logic       begin_execution, flush_partial, flush_full, global_reset;
  logic       data_mem_stop_request_overide, csr_swap_context, run_irq_handler;
  logic [3:0] irq_ack;
  logic [1:0] irq_id;
  logic [1:0] nest_level;
  logic       done_flag, fault_flag;

  int checks = 0;
  int failures = 0;

  core_controller_irq_fsm #(
    .NUM_IRQ(NUM_IRQ), .NEST_DEPTH(NEST_DEPTH), .TIMEOUT_W(8), .FLUSH_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .master_reset(master_reset), .start_program(start_program),
    .program_done(program_done), .reset_trigger(reset_trigger), .irq_req(irq_req),
    .irq_mask(irq_mask), .ret_from_irq(ret_from_irq), .fetch_ready(fetch_ready),
    .all_ready(all_ready), .data_mem_reset_able(data_mem_reset_able),
    .state_out(state_out), .begin_execution(begin_execution), .flush_partial(flush_partial),
    .flush_full(flush_full), .global_reset(global_reset),
    .data_mem_stop_request_overide(data_mem_stop_request_overide),
    .csr_swap_context(csr_swap_context), .run_irq_handler(run_irq_handler),
    .irq_ack(irq_ack), .irq_id(irq_id), .nest_level(nest_level),
    .done_flag(done_flag), .fault_flag(fault_flag)
  );

  always #5 clk = ~clk;

  // {begin_execution, flush_partial, flush_full, global_reset, mem_stop, run_irq_handler, done, fault}
  function automatic logic [7:0] outs();
    return {begin_execution, flush_partial, flush_full, global_reset,
            data_mem_stop_request_overide, run_irq_handler, done_flag, fault_flag};
  endfunction

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic quiet_inputs();
    master_reset = 0; start_program = 0; program_done = 0; reset_trigger = 0;
    irq_req = '0; irq_mask = '0; ret_from_irq = 0;
    fetch_ready = 0; all_ready = 0; data_mem_reset_able = 0;
  endtask

  task automatic go_idle();
    quiet_inputs();
    master_reset = 1;
    cyc();
    master_reset = 0;
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst = 1;
    cyc(2);
    checks++; if (state_out !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state_out); end
    checks++; if ({outs(), irq_ack, irq_id, nest_level, csr_swap_context} !== 17'd0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", {outs(), irq_ack, irq_id, nest_level, csr_swap_context}); end
    rst = 0;
    cyc();
    checks++; if (state_out !== 3'd0) begin failures++; $display("FAIL reset_release_idle: got %0d expected 0", state_out); end
    $display("test_reset done");
  endtask

  task automatic test_boot();
    go_idle();
    start_program = 1; cyc(); start_program = 0;
    checks++; if (state_out !== 3'd1) begin failures++; $display("FAIL boot_run_state: got %0d expected 1", state_out); end
    checks++; if (outs() !== 8'b1000_0000) begin failures++; $display("FAIL boot_run_outs: got %b expected 10000000", outs()); end
    cyc(9);
    program_done = 1; cyc(); program_done = 0;
    checks++; if (state_out !== 3'd5) begin failures++; $display("FAIL boot_done_state: got %0d expected 5", state_out); end
    checks++; if (outs() !== 8'b0000_0010) begin failures++; $display("FAIL boot_done_outs: got %b expected 00000010", outs()); end
    start_program = 1; cyc(2); start_program = 0;
    checks++; if (state_out !== 3'd5) begin failures++; $display("FAIL done_ignores_start: got %0d expected 5", state_out); end
    master_reset = 1; cyc(); master_reset = 0;
    checks++; if ({state_out, done_flag} !== 4'b000_0) begin failures++; $display("FAIL done_master_reset: got %b expected 0000", {state_out, done_flag}); end
    $display("test_boot done");
  endtask

  task automatic test_two_irq();
    go_idle();
    start_program = 1; cyc(); start_program = 0;
    irq_req = 4'b0110; cyc(); irq_req = '0;
    checks++; if ({state_out, outs()} !== {3'd2, 8'b0100_1000}) begin failures++; $display("FAIL two_irq_drain1: got %b expected 01001001000", {state_out, outs()}); end
    cyc(2);
    checks++; if ({state_out, irq_ack} !== {3'd2, 4'b0000}) begin failures++; $display("FAIL two_irq_drain3: got %b expected 0100000", {state_out, irq_ack}); end
    fetch_ready = 1; data_mem_reset_able = 1; cyc();
    checks++; if (state_out !== 3'd3) begin failures++; $display("FAIL two_irq_handler: got %0d expected 3", state_out); end
    checks++; if ({irq_ack, irq_id, nest_level, csr_swap_context} !== {4'b0010, 2'd1, 2'd1, 1'b1}) begin failures++; $display("FAIL two_irq_accept: got %b expected 001001011", {irq_ack, irq_id, nest_level, csr_swap_context}); end
    checks++; if (outs() !== 8'b1000_0100) begin failures++; $display("FAIL two_irq_handler_outs: got %b expected 10000100", outs()); end
    cyc();
    checks++; if ({irq_ack, csr_swap_context} !== 5'b0) begin failures++; $display("FAIL two_irq_pulse_width: got %b expected 00000", {irq_ack, csr_swap_context}); end
    ret_from_irq = 1; cyc(); ret_from_irq = 0;
    checks++; if ({state_out, nest_level, irq_id, csr_swap_context} !== {3'd1, 2'd0, 2'd0, 1'b1}) begin failures++; $display("FAIL two_irq_return: got %b expected 00100001", {state_out, nest_level, irq_id, csr_swap_context}); end
    $display("test_two_irq done");
  endtask

  task automatic test_nesting();
    go_idle();
    fetch_ready = 1; data_mem_reset_able = 1;
    start_program = 1; cyc(); start_program = 0;
    irq_req = 4'b0100; cyc(); irq_req = '0; cyc(2);
    checks++; if ({state_out, irq_id, nest_level} !== {3'd3, 2'd2, 2'd1}) begin failures++; $display("FAIL nest_first: got %b expected 0111001", {state_out, irq_id, nest_level}); end
    irq_req = 4'b0001; cyc();
    checks++; if ({state_out, irq_id, nest_level} !== {3'd2, 2'd2, 2'd1}) begin failures++; $display("FAIL nest_preempt_drain: got %b expected 0101001", {state_out, irq_id, nest_level}); end
    irq_req = 4'b0010; cyc();
    checks++; if ({state_out, irq_id, nest_level, irq_ack} !== {3'd3, 2'd0, 2'd2, 4'b0001}) begin failures++; $display("FAIL nest_second: got %b expected 01100100001", {state_out, irq_id, nest_level, irq_ack}); end
    cyc(3);
    checks++; if ({state_out, nest_level, irq_ack} !== {3'd3, 2'd2, 4'b0000}) begin failures++; $display("FAIL nest_full_holdoff: got %b expected 011100000", {state_out, nest_level, irq_ack}); end
    ret_from_irq = 1; cyc(); ret_from_irq = 0;
    checks++; if ({state_out, irq_id, nest_level, csr_swap_context} !== {3'd3, 2'd2, 2'd1, 1'b1}) begin failures++; $display("FAIL nest_pop: got %b expected 01110011", {state_out, irq_id, nest_level, csr_swap_context}); end
    cyc();
    checks++; if (state_out !== 3'd2) begin failures++; $display("FAIL nest_after_pop_drain: got %0d expected 2", state_out); end
    cyc(); irq_req = '0;
    checks++; if ({irq_id, nest_level, irq_ack} !== {2'd1, 2'd2, 4'b0010}) begin failures++; $display("FAIL nest_after_pop_accept: got %b expected 01100010", {irq_id, nest_level, irq_ack}); end
    ret_from_irq = 1; cyc(2); ret_from_irq = 0;
    checks++; if ({state_out, nest_level} !== {3'd1, 2'd0}) begin failures++; $display("FAIL nest_unwind: got %b expected 00100", {state_out, nest_level}); end
    $display("test_nesting done");
  endtask

  task automatic test_mask();
    go_idle();
    fetch_ready = 1; data_mem_reset_able = 1;
    start_program = 1; cyc(); start_program = 0;
    irq_req = 4'b0001; irq_mask = 4'b0001; cyc(3);
    checks++; if ({state_out, irq_ack, nest_level} !== {3'd1, 4'b0, 2'd0}) begin failures++; $display("FAIL mask_hold_run: got %b expected 001000000", {state_out, irq_ack, nest_level}); end
    irq_mask = 4'b0000; cyc();
    checks++; if (state_out !== 3'd2) begin failures++; $display("FAIL mask_release: got %0d expected 2", state_out); end
    $display("test_mask done");
  endtask

  task automatic test_reset_priority();
    go_idle();
    fetch_ready = 1; data_mem_reset_able = 1;
    start_program = 1; cyc(); start_program = 0;
    irq_req = 4'b0010; cyc(); irq_req = '0; cyc();
    checks++; if ({state_out, nest_level} !== {3'd3, 2'd1}) begin failures++; $display("FAIL rstpri_in_handler: got %b expected 01101", {state_out, nest_level}); end
    reset_trigger = 1; irq_req = 4'b0001; program_done = 1; cyc();
    reset_trigger = 0; irq_req = '0; program_done = 0;
    checks++; if ({state_out, nest_level, irq_id} !== {3'd4, 2'd0, 2'd0}) begin failures++; $display("FAIL rstpri_flush: got %b expected 1000000", {state_out, nest_level, irq_id}); end
    checks++; if (outs() !== 8'b0011_1000) begin failures++; $display("FAIL rstpri_flush_outs: got %b expected 00111000", outs()); end
    cyc(2);
    checks++; if (state_out !== 3'd4) begin failures++; $display("FAIL rstpri_flush_wait: got %0d expected 4", state_out); end
    all_ready = 1; cyc();
    checks++; if ({state_out, outs()} !== 11'd0) begin failures++; $display("FAIL rstpri_idle: got %b expected 0", {state_out, outs()}); end
    $display("test_reset_priority done");
  endtask

  task automatic test_watchdog();
    go_idle();
    data_mem_reset_able = 1;
    start_program = 1; cyc(); start_program = 0;
    irq_req = 4'b0001; cyc(); irq_req = '0;
    cyc(TIMEOUT - 1);
    checks++; if (state_out !== 3'd2) begin failures++; $display("FAIL wd_drain_200: got %0d expected 2", state_out); end
    cyc();
    checks++; if ({state_out, outs()} !== {3'd6, 8'b0001_0001}) begin failures++; $display("FAIL wd_fault: got %b expected 11000010001", {state_out, outs()}); end
    start_program = 1; fetch_ready = 1; cyc(5); start_program = 0; fetch_ready = 0;
    checks++; if ({state_out, fault_flag} !== {3'd6, 1'b1}) begin failures++; $display("FAIL wd_fault_sticky: got %b expected 1101", {state_out, fault_flag}); end
    master_reset = 1; cyc(); master_reset = 0;
    checks++; if ({state_out, fault_flag} !== 4'b0) begin failures++; $display("FAIL wd_fault_clear: got %b expected 0000", {state_out, fault_flag}); end
    // Ready in the limit cycle wins over the timeout.
    start_program = 1; cyc(); start_program = 0;
    irq_req = 4'b0001; cyc(); irq_req = '0;
    cyc(TIMEOUT - 1);
    fetch_ready = 1; cyc(); fetch_ready = 0;
    checks++; if ({state_out, nest_level, fault_flag} !== {3'd3, 2'd1, 1'b0}) begin failures++; $display("FAIL wd_ready_at_limit: got %b expected 011010", {state_out, nest_level, fault_flag}); end
    // Flush watchdog.
    reset_trigger = 1; cyc(); reset_trigger = 0;
    cyc(TIMEOUT - 1);
    checks++; if (state_out !== 3'd4) begin failures++; $display("FAIL wd_flush_200: got %0d expected 4", state_out); end
    cyc();
    checks++; if ({state_out, fault_flag} !== {3'd6, 1'b1}) begin failures++; $display("FAIL wd_flush_fault: got %b expected 1101", {state_out, fault_flag}); end
    $display("test_watchdog done");
  endtask

  // ---------------- behavioural reference for randomized traffic ----------------
  int         m_state;
  int         m_stk[$];
  int         m_wd;
  int         m_pend;
  logic [3:0] m_ack;
  bit         m_swap;

  function automatic int lowest_set(input logic [3:0] v);
    for (int i = 0; i < NUM_IRQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    int w;
    w = lowest_set(irq_req & ~irq_mask);
    m_ack = '0; m_swap = 0;
    if (master_reset) begin
      m_state = 0; m_stk.delete(); m_wd = 0;
    end else begin
      case (m_state)
        0: if (start_program) m_state = 1;
        1: if (reset_trigger) begin m_state = 4; m_wd = 0; end
           else if (w >= 0) begin m_pend = w; m_wd = 0; m_state = 2; end
           else if (program_done) m_state = 5;
        2: if (fetch_ready && data_mem_reset_able) begin
             m_stk.push_back(m_pend); m_ack[m_pend] = 1'b1; m_swap = 1; m_wd = 0; m_state = 3;
           end else begin
             m_wd++; if (m_wd == TIMEOUT) m_state = 6;
           end
        3: if (reset_trigger) begin m_stk.delete(); m_wd = 0; m_state = 4; end
           else if (ret_from_irq) begin
             void'(m_stk.pop_back()); m_swap = 1;
             if (m_stk.size() == 0) m_state = 1;
           end else if (w >= 0 && w < m_stk[$] && m_stk.size() < NEST_DEPTH) begin
             m_pend = w; m_wd = 0; m_state = 2;
           end
        4: if (all_ready && data_mem_reset_able) begin m_wd = 0; m_state = 0; end
           else begin m_wd++; if (m_wd == TIMEOUT) m_state = 6; end
        default: ;
      endcase
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_outs;
    int         exp_id;
    quiet_inputs();
    master_reset = 1;
    model_step();
    cyc();
    for (int n = 0; n < 2000; n++) begin
      master_reset        = ($urandom_range(0, 99) == 0);
      start_program       = ($urandom_range(0, 3) == 0);
      program_done        = ($urandom_range(0, 19) == 0);
      reset_trigger       = ($urandom_range(0, 39) == 0);
      irq_req             = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      irq_mask            = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      ret_from_irq        = ($urandom_range(0, 4) == 0);
      fetch_ready         = $urandom_range(0, 1) == 1;
      all_ready           = $urandom_range(0, 1) == 1;
      data_mem_reset_able = $urandom_range(0, 3) != 0;
      model_step();
      cyc();
      exp_id   = (m_stk.size() != 0) ? m_stk[$] : 0;
      exp_outs = {m_state == 1 || m_state == 3, m_state == 2, m_state == 4, m_state == 4 || m_state == 6,
                  m_state == 2 || m_state == 4, m_state == 3, m_state == 5, m_state == 6};
      checks++; if (int'(state_out) != m_state) begin failures++; $display("FAIL rand_state cyc %0d: got %0d expected %0d", n, state_out, m_state); end
      checks++; if (outs() !== exp_outs) begin failures++; $display("FAIL rand_outs cyc %0d: got %b expected %b", n, outs(), exp_outs); end
      checks++; if (int'(nest_level) != m_stk.size() || int'(irq_id) != exp_id) begin failures++; $display("FAIL rand_stack cyc %0d: got lvl %0d id %0d expected lvl %0d id %0d", n, nest_level, irq_id, m_stk.size(), exp_id); end
      checks++; if ({irq_ack, csr_swap_context} !== {m_ack, m_swap}) begin failures++; $display("FAIL rand_pulses cyc %0d: got %b expected %b", n, {irq_ack, csr_swap_context}, {m_ack, m_swap}); end
    end
    $display("test_random done");
  endtask

  initial begin
    rst = 1;
    quiet_inputs();
    test_reset();
    test_boot();
    test_two_irq();
    test_nesting();
    test_mask();
    test_reset_priority();
    test_watchdog();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
